// File: rtl/ahblite_apb_bridge_pkg.sv
// Shared encodings for the AHB-Lite to APB3 bridge: HTRANS, HRESP and FSM states.
package ahblite_apb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

endpackage

// File: rtl/ahblite_apb_bridge.sv
// AHB-Lite slave turning single transfers into APB3 SETUP/ACCESS cycles,
// with a PREADY timeout so a dead peripheral cannot stall the AHB bus.
module ahblite_apb_bridge
  import ahblite_apb_bridge_pkg::*;
#(
  parameter int PADDR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic               HREADY,
  input  logic [31:0]        HWDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic [PADDR_W-1:0] PADDR,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, nxt;
  logic [7:0]  cnt;
  logic        accept;
  logic        load_addr, load_rdata, cnt_clr, cnt_inc;

  // Upper address bits are decoded upstream; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:PADDR_W], HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt        = state;
    load_addr  = 1'b0;
    load_rdata = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          nxt       = ST_SETUP;
          load_addr = 1'b1;
          cnt_clr   = 1'b1;
        end else begin
          nxt = ST_IDLE;
        end
      end
      ST_SETUP: nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          nxt        = PSLVERR ? ST_ERR1 : ST_DONE;
          load_rdata = !PSLVERR && !PWRITE;
        end else begin
          cnt_inc = 1'b1;
          // Give up on the peripheral; the ERROR response frees the bus.
          if (cnt == CNT_LAST) nxt = ST_ERR1;
        end
      end
      ST_ERR1: nxt = ST_ERR2;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      HRDATA <= '0;
      cnt    <= '0;
    end else begin
      if (load_addr) begin
        PADDR  <= HADDR[PADDR_W-1:0];
        PWRITE <= HWRITE;
      end
      if (load_rdata) HRDATA <= PRDATA;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 8'd1;
    end
  end

  // Bus-facing controls decode straight from state so reset takes effect immediately.
  assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE   = (state == ST_ACCESS);
  assign HREADYOUT = !((state == ST_SETUP) || (state == ST_ACCESS) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign PWDATA    = HWDATA;

endmodule

// File: tb/tb_ahblite_apb_bridge.sv
// Directed bench for ahblite_apb_bridge: latency, errors, timeout, back-to-back and async reset.
module tb_ahblite_apb_bridge;
  import ahblite_apb_bridge_pkg::*;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA, PWDATA, PRDATA;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [15:0] PADDR;

  int tests = 0;
  int fails = 0;

  int          waits, psel_n, pen_n, err1_n;
  logic        err1_psel, cap_pwrite;
  logic [15:0] cap_paddr;
  logic [31:0] cap_pwdata;

  ahblite_apb_bridge #(.PADDR_W(16), .TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Single slave on the bus: the bus-level ready is this slave's ready.
  assign HREADY = HREADYOUT;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one transfer from an accepting cycle and runs its data phase until HREADYOUT=1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int ready_after, input logic slverr);
    bit done;
    HSEL = 1'b1; HADDR = addr; HTRANS = HTRANS_NONSEQ; HWRITE = wr;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_IDLE;
    HWDATA = wr ? data : 32'h0;
    PRDATA = wr ? ~data : data;
    waits = 0; psel_n = 0; pen_n = 0; err1_n = 0; err1_psel = 1'b1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (HREADYOUT === 1'b1) done = 1'b1;
      else begin
        waits++;
        if (PSEL) psel_n++;
        if (HRESP) begin err1_n++; err1_psel = PSEL; end
        if (PENABLE) begin
          if (pen_n == 0) begin cap_paddr = PADDR; cap_pwrite = PWRITE; cap_pwdata = PWDATA; end
          PREADY  = (pen_n >= ready_after);
          PSLVERR = slverr;
          pen_n++;
        end else begin
          PREADY = 1'b0; PSLVERR = 1'b0;
        end
        @(posedge HCLK); #1;
      end
    end
    chk("xfer_completes", 32'(done), 32'd1);
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #12;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp",     32'(HRESP),     32'd0);
    chk("rst_hrdata",    HRDATA,         32'h0);
    chk("rst_psel",      32'(PSEL),      32'd0);
    chk("rst_penable",   32'(PENABLE),   32'd0);
    chk("rst_pwrite",    32'(PWRITE),    32'd0);
    chk("rst_paddr",     32'(PADDR),     32'h0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // 1: zero-wait write
    xfer(1'b1, 32'h4000_0010, 32'hCAFE_F00D, 0, 1'b0);
    chk("t1_waits",  32'(waits),      32'd2);
    chk("t1_psel",   32'(psel_n),     32'd2);
    chk("t1_pen",    32'(pen_n),      32'd1);
    chk("t1_paddr",  32'(cap_paddr),  32'h0010);
    chk("t1_pwrite", 32'(cap_pwrite), 32'd1);
    chk("t1_pwdata", cap_pwdata,      32'hCAFE_F00D);
    chk("t1_hresp",  32'(HRESP),      32'd0);
    chk("t1_done_psel", 32'(PSEL),    32'd0);
    @(posedge HCLK); #1;

    // 2: read with 3 APB wait cycles
    xfer(1'b0, 32'h4000_0024, 32'h1234_5678, 3, 1'b0);
    chk("t2_waits",  32'(waits),      32'd5);
    chk("t2_psel",   32'(psel_n),     32'd5);
    chk("t2_pen",    32'(pen_n),      32'd4);
    chk("t2_paddr",  32'(cap_paddr),  32'h0024);
    chk("t2_pwrite", 32'(cap_pwrite), 32'd0);
    chk("t2_hrdata", HRDATA,          32'h1234_5678);
    chk("t2_hresp",  32'(HRESP),      32'd0);
    @(posedge HCLK); #1;

    // 3: write answered with PSLVERR
    xfer(1'b1, 32'h4000_0030, 32'h0000_DEAD, 0, 1'b1);
    chk("t3_waits",  32'(waits),  32'd3);
    chk("t3_err1",   32'(err1_n), 32'd1);
    chk("t3_err2_hresp", 32'(HRESP), 32'd1);
    chk("t3_hrdata", HRDATA,      32'h1234_5678);
    @(posedge HCLK); #1;
    chk("t3_idle_hresp", 32'(HRESP),     32'd0);
    chk("t3_idle_ready", 32'(HREADYOUT), 32'd1);

    // 4: PREADY stuck low, then a read straight out of ERR2
    xfer(1'b0, 32'h4000_0040, 32'hFFFF_0000, 100, 1'b0);
    chk("t4_waits",  32'(waits),     32'd6);
    chk("t4_pen",    32'(pen_n),     32'd4);
    chk("t4_psel",   32'(psel_n),    32'd5);
    chk("t4_err1",   32'(err1_n),    32'd1);
    chk("t4_err1_psel", 32'(err1_psel), 32'd0);
    chk("t4_hresp",  32'(HRESP),     32'd1);
    chk("t4_hrdata", HRDATA,         32'h1234_5678);
    xfer(1'b0, 32'h4000_0044, 32'hA5A5_5A5A, 0, 1'b0);
    chk("t4b_waits",  32'(waits), 32'd2);
    chk("t4b_hrdata", HRDATA,     32'hA5A5_5A5A);
    chk("t4b_hresp",  32'(HRESP), 32'd0);
    @(posedge HCLK); #1;

    // 5: back-to-back read then write, then idle / deselected cycles
    xfer(1'b0, 32'h4000_0050, 32'h0BAD_BEEF, 0, 1'b0);
    chk("t5r_waits",  32'(waits), 32'd2);
    chk("t5r_hrdata", HRDATA,     32'h0BAD_BEEF);
    xfer(1'b1, 32'h4000_0054, 32'h1122_3344, 0, 1'b0);
    chk("t5w_waits",  32'(waits),      32'd2);
    chk("t5w_paddr",  32'(cap_paddr),  32'h0054);
    chk("t5w_pwdata", cap_pwdata,      32'h1122_3344);
    chk("t5w_hrdata", HRDATA,          32'h0BAD_BEEF);
    @(posedge HCLK); #1;
    chk("t5_idle_psel",  32'(PSEL),      32'd0);
    chk("t5_idle_ready", 32'(HREADYOUT), 32'd1);
    HSEL = 1'b0; HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1;
    chk("t5_nosel_psel",  32'(PSEL),      32'd0);
    chk("t5_nosel_ready", 32'(HREADYOUT), 32'd1);
    chk("t5_nosel_hresp", 32'(HRESP),     32'd0);
    HSEL = 1'b1; HTRANS = HTRANS_BUSY;
    @(posedge HCLK); #1;
    chk("t5_busy_psel",  32'(PSEL),      32'd0);
    chk("t5_busy_ready", 32'(HREADYOUT), 32'd1);
    HTRANS = HTRANS_IDLE;

    // 6: asynchronous reset during ACCESS
    HADDR = 32'h4000_0060; HWRITE = 1'b0; HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_IDLE;
    @(posedge HCLK); #1;
    chk("t6_access_pen", 32'(PENABLE), 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    chk("t6_rst_psel",   32'(PSEL),      32'd0);
    chk("t6_rst_pen",    32'(PENABLE),   32'd0);
    chk("t6_rst_ready",  32'(HREADYOUT), 32'd1);
    chk("t6_rst_hrdata", HRDATA,         32'h0);
    chk("t6_rst_paddr",  32'(PADDR),     32'h0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(1'b1, 32'h4000_0070, 32'h55AA_55AA, 0, 1'b0);
    chk("t6_waits",  32'(waits),     32'd2);
    chk("t6_paddr",  32'(cap_paddr), 32'h0070);
    chk("t6_pwdata", cap_pwdata,     32'h55AA_55AA);
    chk("t6_hresp",  32'(HRESP),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
